// File: rtl/fabric_cfg_ctrl.sv
// fabric_cfg_ctrl: configuration/run sequencer for a small CLB fabric.
// Streams one bitstream frame per tile (tile 0 first) with a per-tile ready
// handshake, holds execution off until every tile is loaded, and counts the
// cycles spent running.
// Optional feature macro: FRAME_CHECK_EN -- when defined, an accepted beat whose
// cfg_tlast disagrees with the expected end of frame sends the block to ERROR.
module fabric_cfg_ctrl #(
    parameter int NUM_CLBS      = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int WORDS_PER_CLB = 4,
    parameter int COUNT_WIDTH   = 16,
    localparam int CW = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1,
    localparam int WW = (WORDS_PER_CLB > 1) ? $clog2(WORDS_PER_CLB) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg,
    input  logic [DATA_WIDTH-1:0]  cfg_tdata,
    input  logic                   cfg_tvalid,
    input  logic                   cfg_tlast,
    output logic                   cfg_tready,
    output logic [DATA_WIDTH-1:0]  clb_cfg_data,
    output logic [NUM_CLBS-1:0]    clb_cfg_valid,
    output logic                   clb_cfg_last,
    input  logic [NUM_CLBS-1:0]    clb_cfg_ready,
    input  logic                   run,
    output logic                   run_en,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [CW-1:0]          cur_clb,
    output logic [COUNT_WIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_INIT,
        S_CONFIG,
        S_IDLE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [CW-1:0] LAST_CLB  = CW'(NUM_CLBS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_CLB - 1);

    state_t                 state_q, state_d;
    logic [WW-1:0]          word_cnt_q, word_cnt_d;
    logic [CW-1:0]          cur_clb_q, cur_clb_d;
    logic                   cfg_done_q, cfg_done_d;
    logic [COUNT_WIDTH-1:0] run_cycles_q, run_cycles_d;

    logic                   in_cfg;
    logic [NUM_CLBS-1:0]    rdy_shift;
    logic                   accept;
    logic                   frame_bad;

    // Handshake and tile-facing outputs, decoded from the registered state
    always_comb begin
        in_cfg        = (state_q == S_CONFIG);
        rdy_shift     = clb_cfg_ready >> cur_clb_q;
        cfg_tready    = in_cfg & rdy_shift[0];
        clb_cfg_valid = (in_cfg && cfg_tvalid) ? (NUM_CLBS'(1) << cur_clb_q) : '0;
        clb_cfg_last  = in_cfg && (word_cnt_q == LAST_WORD);
        clb_cfg_data  = cfg_tdata;
        accept        = cfg_tready & cfg_tvalid;
        run_en        = (state_q == S_RUN);
        cfg_busy      = in_cfg;
        cfg_err       = (state_q == S_ERROR);
        cfg_done      = cfg_done_q;
        cur_clb       = cur_clb_q;
        run_cycles    = run_cycles_q;
    end

`ifdef FRAME_CHECK_EN
    assign frame_bad = (cfg_tlast != clb_cfg_last);
`else
    // Frames are delimited purely by the word counter; tlast is not consulted
    logic unused_tlast;
    assign unused_tlast = cfg_tlast;
    assign frame_bad    = 1'b0;
`endif

    // Next-state logic for the sequencer, frame counters and run counter
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        cur_clb_d    = cur_clb_q;
        cfg_done_d   = cfg_done_q;
        run_cycles_d = run_cycles_q;
        case (state_q)
            S_INIT, S_ERROR: begin
                if (cfg) begin
                    state_d    = S_CONFIG;
                    word_cnt_d = '0;
                    cur_clb_d  = '0;
                    cfg_done_d = 1'b0;
                end
            end
            S_CONFIG: begin
                if (accept) begin
                    if (frame_bad) begin
                        state_d = S_ERROR;
                    end else if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        if (cur_clb_q == LAST_CLB) begin
                            cur_clb_d  = '0;
                            state_d    = S_IDLE;
                            cfg_done_d = 1'b1;
                        end else begin
                            cur_clb_d = cur_clb_q + 1'b1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (cfg) begin
                    state_d    = S_CONFIG;
                    word_cnt_d = '0;
                    cur_clb_d  = '0;
                    cfg_done_d = 1'b0;
                end else if (run) begin
                    state_d      = S_RUN;
                    run_cycles_d = '0;
                end
            end
            S_RUN: begin
                // The exit cycle still counts, so N cycles of run_en give N
                run_cycles_d = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 1'b1;
                if (cfg) begin
                    state_d    = S_CONFIG;
                    word_cnt_d = '0;
                    cur_clb_d  = '0;
                    cfg_done_d = 1'b0;
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            word_cnt_q   <= '0;
            cur_clb_q    <= '0;
            cfg_done_q   <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            cur_clb_q    <= cur_clb_d;
            cfg_done_q   <= cfg_done_d;
            run_cycles_q <= run_cycles_d;
        end
    end

endmodule

// File: tb/tb_fabric_cfg_ctrl.sv
// Directed bench for fabric_cfg_ctrl: a 4x4 default instance plus a
// single-tile, single-word instance with a 4-bit run counter.
module tb_fabric_cfg_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (4 tiles x 4 words, 16-bit counter)
    logic        rst, cfg, tvalid, tlast, run;
    logic [7:0]  tdata;
    logic [3:0]  rdy;
    logic        tready, clast, run_en, busy, done, err;
    logic [7:0]  cdata;
    logic [3:0]  cvalid;
    logic [1:0]  cur;
    logic [15:0] rcyc;

    fabric_cfg_ctrl dut (
        .clk(clk), .rst(rst), .cfg(cfg), .cfg_tdata(tdata), .cfg_tvalid(tvalid),
        .cfg_tlast(tlast), .cfg_tready(tready), .clb_cfg_data(cdata),
        .clb_cfg_valid(cvalid), .clb_cfg_last(clast), .clb_cfg_ready(rdy),
        .run(run), .run_en(run_en), .cfg_busy(busy), .cfg_done(done),
        .cfg_err(err), .cur_clb(cur), .run_cycles(rcyc)
    );

    // Single tile, single word, 4-bit counter
    logic       s_rst, s_cfg, s_tvalid, s_tlast, s_run, s_rdy;
    logic [7:0] s_tdata, s_cdata;
    logic       s_tready, s_valid, s_last, s_run_en, s_busy, s_done, s_err;
    logic       s_cur;
    logic [3:0] s_rcyc;

    fabric_cfg_ctrl #(.NUM_CLBS(1), .DATA_WIDTH(8), .WORDS_PER_CLB(1), .COUNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(s_rst), .cfg(s_cfg), .cfg_tdata(s_tdata), .cfg_tvalid(s_tvalid),
        .cfg_tlast(s_tlast), .cfg_tready(s_tready), .clb_cfg_data(s_cdata),
        .clb_cfg_valid(s_valid), .clb_cfg_last(s_last), .clb_cfg_ready(s_rdy),
        .run(s_run), .run_en(s_run_en), .cfg_busy(s_busy), .cfg_done(s_done),
        .cfg_err(s_err), .cur_clb(s_cur), .run_cycles(s_rcyc)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic       cfg, tvalid, tlast;
        logic [3:0] rdy;
        logic       run;
        // expected {tready, valid[3:0], last, busy, done, err, cur[1:0], run_en}
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic c, input logic v, input logic l,
                                input logic [3:0] r, input logic rn, input logic e_rdy,
                                input logic [3:0] e_val, input logic e_last, input logic e_busy,
                                input logic e_done, input logic e_err, input logic [1:0] e_cur,
                                input logic e_ren);
        vec_t t;
        t.name = nm; t.cfg = c; t.tvalid = v; t.tlast = l; t.rdy = r; t.run = rn;
        t.exp = {e_rdy, e_val, e_last, e_busy, e_done, e_err, e_cur, e_ren};
        return t;
    endfunction

    vec_t tbl[20];
    int unsigned acc;
    int unsigned hi;
    int unsigned n;
    logic stall;

    initial begin
        tbl[0]  = mk("rst_state", 0,0,0,4'hF,0, 0,4'b0000,0,0,0,0,2'd0,0);
        tbl[1]  = mk("init_run",  0,0,0,4'hF,1, 0,4'b0000,0,0,0,0,2'd0,0);
        tbl[2]  = mk("init_cfg",  1,0,0,4'hF,0, 0,4'b0000,0,0,0,0,2'd0,0);
        tbl[3]  = mk("t0w0",      0,1,0,4'hF,0, 1,4'b0001,0,1,0,0,2'd0,0);
        tbl[4]  = mk("t0w1",      0,1,0,4'hF,0, 1,4'b0001,0,1,0,0,2'd0,0);
        tbl[5]  = mk("t0w2",      0,1,0,4'hF,0, 1,4'b0001,0,1,0,0,2'd0,0);
        tbl[6]  = mk("t0w3",      0,1,1,4'hF,0, 1,4'b0001,1,1,0,0,2'd0,0);
        tbl[7]  = mk("t1w0",      0,1,0,4'hF,0, 1,4'b0010,0,1,0,0,2'd1,0);
        tbl[8]  = mk("t1w1",      0,1,0,4'hF,0, 1,4'b0010,0,1,0,0,2'd1,0);
        tbl[9]  = mk("t1w2",      0,1,0,4'hF,0, 1,4'b0010,0,1,0,0,2'd1,0);
        tbl[10] = mk("t1w3",      0,1,1,4'hF,0, 1,4'b0010,1,1,0,0,2'd1,0);
        tbl[11] = mk("t2w0",      0,1,0,4'hF,0, 1,4'b0100,0,1,0,0,2'd2,0);
        tbl[12] = mk("t2w1",      0,1,0,4'hF,0, 1,4'b0100,0,1,0,0,2'd2,0);
        tbl[13] = mk("t2w2",      0,1,0,4'hF,0, 1,4'b0100,0,1,0,0,2'd2,0);
        tbl[14] = mk("t2w3",      0,1,1,4'hF,0, 1,4'b0100,1,1,0,0,2'd2,0);
        tbl[15] = mk("t3w0",      0,1,0,4'hF,0, 1,4'b1000,0,1,0,0,2'd3,0);
        tbl[16] = mk("t3w1",      0,1,0,4'hF,0, 1,4'b1000,0,1,0,0,2'd3,0);
        tbl[17] = mk("t3w2",      0,1,0,4'hF,0, 1,4'b1000,0,1,0,0,2'd3,0);
        tbl[18] = mk("t3w3",      0,1,1,4'hF,0, 1,4'b1000,1,1,0,0,2'd3,0);
        tbl[19] = mk("idle_done", 0,0,0,4'hF,0, 0,4'b0000,0,0,1,0,2'd0,0);

        rst = 1; cfg = 0; tvalid = 0; tlast = 0; run = 0; tdata = 8'h00; rdy = 4'hF;
        s_rst = 1; s_cfg = 0; s_tvalid = 0; s_tlast = 0; s_run = 0; s_tdata = 8'h00; s_rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0; s_rst = 0;
        chk("rst_run_cycles", 32'(rcyc), 32'd0);

        // Full 4x4 configuration stream
        for (int i = 0; i < 20; i++) begin
            cfg = tbl[i].cfg; tvalid = tbl[i].tvalid; tlast = tbl[i].tlast;
            rdy = tbl[i].rdy; run = tbl[i].run; tdata = 8'(8'hA0 + i);
            #1;
            chk(tbl[i].name, 32'({tready, cvalid, clast, busy, done, err, cur, run_en}),
                32'(tbl[i].exp));
            if (tvalid) chk({tbl[i].name, "_data"}, 32'(cdata), 32'(8'hA0 + i));
            tick();
        end
        tvalid = 0; tlast = 0;

        // Run for 10 sampled cycles: run_en lags run by one cycle
        run = 1;
        #1;
        chk("run_lag", 32'(run_en), 32'd0);
        hi = 0;
        repeat (10) begin
            tick();
            if (run_en) hi++;
        end
        run = 0;
        tick();
        chk("run_en_cycles", hi, 32'd10);
        chk("run_en_off", 32'(run_en), 32'd0);
        chk("run_cycles_10", 32'(rcyc), 32'd10);
        tick();
        chk("run_cycles_hold", 32'(rcyc), 32'd10);
        chk("done_after_run", 32'(done), 32'd1);

        // Reconfigure with tile 1 stalled for 5 cycles
        cfg = 1;
        tick();
        cfg = 0;
        chk("recfg_done_clr", 32'(done), 32'd0);
        acc = 0; n = 0;
        while (!done && n < 60) begin
            stall = (n >= 5 && n < 10);
            tvalid = 1;
            tlast = ((acc % 4) == 3);
            rdy = stall ? 4'b1101 : 4'hF;
            #1;
            if (stall) begin
                chk("stall_tready", 32'(tready), 32'd0);
                chk("stall_cur", 32'(cur), 32'd1);
            end else begin
                acc++;
            end
            tick();
            n++;
        end
        tvalid = 0; tlast = 0; rdy = 4'hF;
        chk("stall_latency", n, 32'd21);
        chk("stall_done", 32'(done), 32'd1);

        // cfg and run together while running: cfg wins
        run = 1;
        tick();
        tick();
        chk("run_again", 32'(run_en), 32'd1);
        cfg = 1;
        tick();
        cfg = 0; run = 0;
        chk("cfg_prio_run_en", 32'(run_en), 32'd0);
        chk("cfg_prio_done", 32'(done), 32'd0);
        chk("cfg_prio_busy", 32'(busy), 32'd1);
        chk("cfg_prio_cur", 32'(cur), 32'd0);

        // Reset after 6 accepted beats
        for (int k = 0; k < 6; k++) begin
            tvalid = 1; tlast = (k == 3);
            tick();
        end
        chk("pre_rst_cur", 32'(cur), 32'd1);
        tvalid = 0; tlast = 0; rst = 1;
        tick();
        chk("rst_outputs", 32'({tready, cvalid, clast, busy, done, err, cur, run_en}), 32'd0);
        chk("rst_run_cycles2", 32'(rcyc), 32'd0);
        rst = 0; cfg = 1;
        tick();
        cfg = 0; tvalid = 1; tlast = 0;
        #1;
        chk("restart_valid", 32'(cvalid), 32'b0001);
        chk("restart_last", 32'(clast), 32'd0);
        chk("restart_tready", 32'(tready), 32'd1);

        // Rogue tlast on the second beat of tile 0
        tick();
        tlast = 1;
        tick();
        tvalid = 0; tlast = 0;
`ifdef FRAME_CHECK_EN
        chk("err_set", 32'(err), 32'd1);
        chk("err_tready", 32'(tready), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        run = 1;
        tick();
        chk("err_run_ignored", 32'(run_en), 32'd0);
        chk("err_hold", 32'(err), 32'd1);
        run = 0; cfg = 1;
        tick();
        cfg = 0; tvalid = 1;
        #1;
        chk("err_clear", 32'(err), 32'd0);
        chk("err_recfg_cur", 32'(cur), 32'd0);
        chk("err_recfg_valid", 32'(cvalid), 32'b0001);
        chk("err_recfg_last", 32'(clast), 32'd0);
`else
        chk("noerr_err", 32'(err), 32'd0);
        chk("noerr_busy", 32'(busy), 32'd1);
        chk("noerr_cur", 32'(cur), 32'd0);
        tvalid = 1;
        #1;
        chk("noerr_valid", 32'(cvalid), 32'b0001);
        chk("noerr_last", 32'(clast), 32'd0);
`endif
        tvalid = 0;

        // Single-tile / single-word instance with saturating 4-bit counter
        chk("s_rst_outputs", 32'({s_tready, s_valid, s_last, s_busy, s_done, s_err, s_run_en}), 32'd0);
        s_cfg = 1;
        tick();
        s_cfg = 0; s_tvalid = 1; s_tlast = 1;
        #1;
        chk("s_beat", 32'({s_tready, s_valid, s_last, s_busy, s_cur}), 32'b11110);
        tick();
        s_tvalid = 0; s_tlast = 0;
        chk("s_done", 32'({s_done, s_busy}), 32'b10);
        s_run = 1;
        repeat (20) tick();
        s_run = 0;
        tick();
        chk("s_run_sat", 32'(s_rcyc), 32'd15);
        chk("s_run_off", 32'(s_run_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
